uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the baud-rate divider. It accepts bytes over a valid/ready handshake into a small FIFO and shifts each byte out LSB-first as an async-serial frame: start bit, data, optional parity, and stop bit(s). Bit boundaries are paced by a single-cycle `baud_tick` enable in the `clk` domain, so the block has no derived clock.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–8).
- `FIFO_DEPTH`, 4: transmit FIFO entries; must be a power of 2, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `baud_tick`  in  1  one-`clk`-cycle pulse per bit period, from the divider.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte (= not full).
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `fifo_count`  out  log2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Push: `tx_valid && tx_ready` on a rising `clk` writes `tx_data`. Data written in cycle N is poppable from cycle N+1.
- Pop: the serializer pops the FIFO head on the tick that starts a frame.
- Simultaneous push and pop: `fifo_count` is unchanged. A push when full is impossible because `tx_ready` is 0 and the data is ignored.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full = `count == FIFO_DEPTH`; empty = `count == 0`.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles with `baud_tick == 1`.
  - IDLE: `tx = 1`. On tick with FIFO non-empty: pop head into the shift register, set `tx = 0`, clear `bit_cnt`, go to START. On tick with FIFO empty: stay in IDLE.
  - START: on tick, drive `tx = shift[0]`, shift right, go to DATA.
  - DATA: on tick, if `bit_cnt == DATA_BITS-1`:
    - If PARITY ≠ 0: drive the parity bit and go to PARITY.
    - Otherwise: drive `tx = 1` and go to STOP.
    - In both cases, reset `bit_cnt`.
  - DATA: on tick otherwise, drive the next data bit, shift, and increment `bit_cnt`.
  - PARITY: on tick, drive `tx = 1` and go to STOP.
  - STOP: on tick, if `stop_cnt == STOP_BITS-1`, go to IDLE; otherwise increment `stop_cnt`.
    - If the FIFO is non-empty on that exit tick, go directly to START: pop, drive `tx = 0`. This gives back-to-back frames with no idle gap.
    - Otherwise, go to IDLE with `tx = 1`.
- Parity is computed over the popped byte at pop time.
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- `baud_tick` asserted for multiple consecutive cycles is treated as one tick per cycle; the block does not filter it.

## Timing
- Reset values: `tx = 1`, `busy = 0`, `tx_ready = 1`, `fifo_count = 0`; FSM in IDLE; FIFO pointers and counters at 0.
- Reset mid-frame: `tx` goes to 1 asynchronously, the frame is aborted, and FIFO contents are discarded.
- Every line bit (start, data, parity, stop) lasts exactly one tick period.
- Frame length in ticks: 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS.
- Latency from an accepted push into an idle block: the start bit begins on the first `baud_tick` occurring at least 1 cycle after the push cycle.
- `tx` changes only in the cycle after a sampled tick, since it is a registered output.
- `busy` rises with the start bit and falls in the cycle after the final stop tick, unless a back-to-back frame follows.
- `tx_ready` is combinational from the FIFO count; it deasserts in the cycle after the push that fills the FIFO.

## Test plan
- Defaults, ticks every 4 cycles, push 0xA5 once: `tx` shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles wide; `busy` is high for 10 ticks; `fifo_count` returns to 0.
- PARITY=1, STOP_BITS=2, push 0xA5: parity bit 0, then two stop bits of 1; frame is 12 ticks. Repeat with PARITY=2: parity bit 1.
- Push 5 bytes back-to-back with no ticks: `tx_ready` drops after the 4th, the 5th is held off, and `fifo_count` = 4. Enable ticks: the 4 frames go out contiguously with no idle bit between stop and start.
- Pop and push in the same cycle while `fifo_count` = 2: `fifo_count` stays 2, and byte order on the line matches push order through pointer wrap (push ≥ 8 bytes total).
- Assert `clr_n = 0` during data bit 3: `tx` = 1 immediately, `busy` = 0, and `fifo_count` = 0. After release, the next pushed byte transmits cleanly.
- No ticks for 100 cycles with a byte queued: `tx` stays 1, `busy` stays 0, and the byte stays in the FIFO (`fifo_count` = 1).

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte FIFO feeding an LSB-first
// async-serial framer (start, data, optional parity, stop bits). Bit
// boundaries are paced by a single-cycle baud_tick enable in the clk domain.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          baud_tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;

  // Framer state
  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;

  assign fifo_empty  = (count_reg == '0);
  assign tx_ready    = (count_reg != FULL_CNT);
  assign push        = tx_valid && tx_ready;
  assign head        = mem[rd_ptr_reg];
  // Odd parity is the inverted data XOR; even (and unused) is the plain XOR.
  assign head_parity = (PARITY == 2) ? ~(^head) : (^head);

  assign tx         = tx_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign fifo_count = count_reg;

  // FIFO data write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Framer registers; tx idles high and returns high immediately on reset
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
    end
  end

  // Next-state and line-bit selection; everything advances only on baud_tick
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    pop           = 1'b0;
    if (baud_tick) begin
      case (state_reg)
        ST_IDLE: begin
          tx_next = 1'b1;
          if (!fifo_empty) begin
            pop          = 1'b1;
            shift_next   = head;
            parity_next  = head_parity;
            bit_cnt_next = '0;
            tx_next      = 1'b0;
            state_next   = ST_START;
          end
        end
        ST_START: begin
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          state_next = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next  = '0;
            stop_cnt_next = 1'b0;
            if (PARITY != 0) begin
              tx_next    = parity_reg;
              state_next = ST_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        ST_PARITY: begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            stop_cnt_next = 1'b0;
            // A queued byte starts immediately so frames run back-to-back.
            if (!fifo_empty) begin
              pop          = 1'b1;
              shift_next   = head;
              parity_next  = head_parity;
              bit_cnt_next = '0;
              tx_next      = 1'b0;
              state_next   = ST_START;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
        default: begin
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: default framing, even/odd parity
// with two stop bits, FIFO full back-pressure, push/pop overlap through
// pointer wrap, mid-frame reset and tick starvation.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       tx_ready0, tx0, busy0;
  logic       tx_ready1, tx1, busy1;
  logic       tx_ready2, tx2, busy2;
  logic [2:0] cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default configuration
  uart_tx_serializer #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .clr_n(clr_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready0), .tx(tx0), .busy(busy0), .fifo_count(cnt0)
  );
  // Even parity, two stop bits
  uart_tx_serializer #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .clr_n(clr_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready1), .tx(tx1), .busy(busy1), .fifo_count(cnt1)
  );
  // Odd parity, two stop bits
  uart_tx_serializer #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k ticks after the frame-starting tick
  function automatic logic exp_bit(input int par, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par != 0 && k == 9) return (par == 1) ? ^b : ~(^b);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int par, input int stops);
    return 9 + ((par != 0) ? 1 : 0) + stops;
  endfunction

  task automatic tick();
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    $display("push %02h", b);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    idle(2);
    clr_n = 1'b1;
    idle(1);
  endtask

  // Safety net so a stuck design still ends the run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  logic [7:0] bytes [10];

  initial begin
    clr_n     = 1'b0;
    baud_tick = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    idle(3);

    // Reset values, checked while reset is held
    check("rst tx", tx0, 1'b1);
    check("rst busy", busy0, 1'b0);
    check("rst ready", tx_ready0, 1'b1);
    check("rst count", cnt0, 3'd0);
    clr_n = 1'b1;
    idle(1);

    // Single 0xA5 frame on all three configurations, ticks every 4 cycles
    push(8'hA5);
    check("a5 count after push", cnt0, 3'd1);
    for (int k = 0; k < 13; k++) begin
      tick();
      check($sformatf("a5 k=%0d tx0", k), tx0, exp_bit(0, 8'hA5, k));
      check($sformatf("a5 k=%0d busy0", k), busy0, (k < frame_len(0, 1)) ? 1'b1 : 1'b0);
      check($sformatf("a5 k=%0d tx1", k), tx1, exp_bit(1, 8'hA5, k));
      check($sformatf("a5 k=%0d busy1", k), busy1, (k < frame_len(1, 2)) ? 1'b1 : 1'b0);
      check($sformatf("a5 k=%0d tx2", k), tx2, exp_bit(2, 8'hA5, k));
      check($sformatf("a5 k=%0d busy2", k), busy2, (k < frame_len(2, 2)) ? 1'b1 : 1'b0);
      if (k == 0) check("a5 count after pop", cnt0, 3'd0);
      idle(3);
      check($sformatf("a5 k=%0d tx0 hold", k), tx0, exp_bit(0, 8'hA5, k));
    end
    check("a5 final count", cnt0, 3'd0);
    $display("frame a5 on three configurations done");

    // Five pushes with no ticks: fifth is held off
    do_reset();
    bytes[0] = 8'h11; bytes[1] = 8'hC3; bytes[2] = 8'h7E; bytes[3] = 8'h80; bytes[4] = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      tx_data  = bytes[i];
      tx_valid = 1'b1;
      check($sformatf("fill ready i=%0d", i), tx_ready0, (i < 4) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    check("fill count", cnt0, 3'd4);
    check("fill ready final", tx_ready0, 1'b0);
    for (int k = 0; k < 41; k++) begin
      tick();
      if (k < 40) begin
        check($sformatf("b2b k=%0d tx", k), tx0, exp_bit(0, bytes[k/10], k % 10));
        check($sformatf("b2b k=%0d busy", k), busy0, 1'b1);
      end else begin
        check("b2b end tx", tx0, 1'b1);
        check("b2b end busy", busy0, 1'b0);
      end
      idle(3);
    end
    check("b2b count", cnt0, 3'd0);
    $display("four back-to-back frames done");

    // Push/pop overlap at count 2, ten bytes through pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) bytes[i] = 8'(8'h2B * (i + 1) + 8'h05);
    push(bytes[0]);
    push(bytes[1]);
    check("wrap prefill count", cnt0, 3'd2);
    for (int f = 0; f < 10; f++) begin
      if (f < 8) begin
        tx_data  = bytes[f+2];
        tx_valid = 1'b1;
      end
      tick();
      tx_valid = 1'b0;
      check($sformatf("wrap f=%0d count", f), cnt0, (f < 8) ? 3'd2 : 3'(9 - f));
      check($sformatf("wrap f=%0d start", f), tx0, 1'b0);
      idle(3);
      for (int k = 1; k < 10; k++) begin
        tick();
        check($sformatf("wrap f=%0d k=%0d tx", f, k), tx0, exp_bit(0, bytes[f], k));
        idle(3);
      end
      $display("frame %0d byte %02h sent", f, bytes[f]);
    end
    tick();
    check("wrap end busy", busy0, 1'b0);
    check("wrap end tx", tx0, 1'b1);

    // No ticks for 100 cycles with a byte queued
    do_reset();
    push(8'h42);
    for (int i = 0; i < 4; i++) begin
      idle(25);
      check($sformatf("notick %0d tx", i), tx0, 1'b1);
      check($sformatf("notick %0d busy", i), busy0, 1'b0);
      check($sformatf("notick %0d count", i), cnt0, 3'd1);
    end

    // Reset during data bit 3
    do_reset();
    push(8'h55);
    push(8'h0F);
    for (int k = 0; k < 5; k++) begin
      tick();
      idle(3);
    end
    check("abort pre tx", tx0, 1'b0);
    check("abort pre busy", busy0, 1'b1);
    check("abort pre count", cnt0, 3'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check("abort tx", tx0, 1'b1);
    check("abort busy", busy0, 1'b0);
    check("abort count", cnt0, 3'd0);
    check("abort ready", tx_ready0, 1'b1);
    @(posedge clk); #1;
    clr_n = 1'b1;
    idle(1);
    push(8'h96);
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("post k=%0d tx", k), tx0, exp_bit(0, 8'h96, k));
      check($sformatf("post k=%0d busy", k), busy0, (k < 10) ? 1'b1 : 1'b0);
      idle(3);
    end
    $display("post-reset frame 96 done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
